pwm_bank: RTL and testbench

Parametrised N-channel PWM generator with a memory-mapped register interface. It is the successor to the fixed three-colour duty/compare logic in the top level. It adds a shared prescaler and programmable period, duty updates double-buffered to the period boundary, and a per-channel linear fade toward a target duty. It sits on the SPI register bus beside the GPIO registers and drives status LEDs or the P1/P2 header pins.

---
 rtl/pwm_bank_pkg.sv | 24 ++
 rtl/pwm_bank_channel.sv | 64 ++++++
 rtl/pwm_bank.sv | 149 ++++++++++++++
 tb/tb_pwm_bank.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// Register map offsets and control/status bit positions shared by the
// pwm_bank top level and its per-channel slices.
package pwm_bank_pkg;

  localparam int REG_CTRL      = 0;
  localparam int REG_PRESCALE  = 1;
  localparam int REG_PERIOD    = 2;
  localparam int REG_STATUS    = 3;
  localparam int REG_CH_BASE   = 4;
  localparam int REG_CH_STRIDE = 2;

  localparam int CTRL_RUN_BIT       = 0;
  localparam int CTRL_FORCE_BIT     = 1;
  localparam int STATUS_PENDING_BIT = 0;

  function automatic int ch_target_offset(input int ch);
    return REG_CH_BASE + REG_CH_STRIDE * ch;
  endfunction

  function automatic int ch_step_offset(input int ch);
    return REG_CH_BASE + REG_CH_STRIDE * ch + 1;
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: TARGET/STEP shadow registers, the active duty with its
// per-period linear fade, and the registered compare output.
module pwm_channel
  import pwm_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] counter,
  input  logic             wrap,
  input  logic             run,
  input  logic             load,
  input  logic             target_we,
  input  logic             step_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] step,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_active;

  // Two guard bits keep both duty+step and duty-step exact, so the clamp
  // to target can never be fooled by wrap-around.
  function automatic logic [WIDTH-1:0] fade_sat(input logic [WIDTH-1:0] duty,
                                                input logic [WIDTH-1:0] tgt,
                                                input logic [WIDTH-1:0] stp);
    logic signed [WIDTH+1:0] d;
    logic signed [WIDTH+1:0] t;
    logic signed [WIDTH+1:0] s;
    logic signed [WIDTH+1:0] nxt;
    d = $signed({2'b00, duty});
    t = $signed({2'b00, tgt});
    s = $signed({2'b00, stp});
    if (s == '0) begin
      nxt = t;
    end else if (d < t) begin
      nxt = (d + s > t) ? t : d + s;
    end else begin
      nxt = (d - s < t) ? t : d - s;
    end
    return nxt[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target      <= '0;
      step        <= '0;
      duty_active <= '0;
      pwm         <= 1'b0;
    end else begin
      if (target_we) target <= wdata;
      if (step_we)   step   <= wdata;
      if (load) begin
        duty_active <= target;
      end else if (wrap) begin
        duty_active <= fade_sat(duty_active, target, step);
      end
      pwm <= run && (counter < duty_active);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// N-channel PWM generator with shared prescaler, double-buffered period and
// per-channel fading duty, exposed through a small register window.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int CHANNELS          = 4,
  parameter int WIDTH             = 16,
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter logic [ADDRESS_BUS_WIDTH-1:0] BASE_ADDRESS = 16'h0010
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [ADDRESS_BUS_WIDTH-1:0] i_address,
  input  logic                         i_write_strobe,
  input  logic                         i_read_strobe,
  input  logic [DATA_BUS_WIDTH-1:0]    i_write_data,
  output logic [DATA_BUS_WIDTH-1:0]    o_read_data,
  output logic [CHANNELS-1:0]          o_pwm,
  output logic                         o_period_strobe
);

  localparam int AW       = ADDRESS_BUS_WIDTH;
  localparam int NUM_REGS = REG_CH_BASE + REG_CH_STRIDE * CHANNELS;
  localparam logic [AW-1:0] LAST_OFFSET = AW'(NUM_REGS - 1);

  logic [AW-1:0]    offset;
  logic             in_range;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;
  logic             force_update;

  logic             run;
  logic [WIDTH-1:0] prescale;
  logic [WIDTH-1:0] period_shadow;
  logic [WIDTH-1:0] period_active;
  logic [WIDTH-1:0] pre_cnt;
  logic [WIDTH-1:0] counter;
  logic             tick;
  logic             wrap;
  logic             load;

  logic [WIDTH-1:0]          ch_target [CHANNELS];
  logic [WIDTH-1:0]          ch_step   [CHANNELS];
  logic [DATA_BUS_WIDTH-1:0] rd_val;

  assign offset       = i_address - BASE_ADDRESS;
  assign in_range     = (i_address >= BASE_ADDRESS) && (offset <= LAST_OFFSET);
  assign wr_en        = i_write_strobe && in_range;
  assign wdata        = i_write_data[WIDTH-1:0];
  assign unused_wdata = ^i_write_data;
  assign force_update = wr_en && (offset == AW'(REG_CTRL)) && i_write_data[CTRL_FORCE_BIT];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run           <= 1'b0;
      prescale      <= '0;
      period_shadow <= '1;
    end else if (wr_en) begin
      if (offset == AW'(REG_CTRL))     run           <= i_write_data[CTRL_RUN_BIT];
      if (offset == AW'(REG_PRESCALE)) prescale      <= wdata;
      if (offset == AW'(REG_PERIOD))   period_shadow <= wdata;
    end
  end

  // Comparisons use >= so a PRESCALE rewrite below the running count cannot
  // strand the prescaler in a full wrap-around of its range.
  assign tick = (pre_cnt >= prescale);
  assign wrap = run && tick && (counter >= period_active);
  assign load = !run || force_update;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_cnt         <= '0;
      counter         <= '0;
      period_active   <= '1;
      o_period_strobe <= 1'b0;
    end else if (load) begin
      pre_cnt         <= '0;
      counter         <= '0;
      period_active   <= period_shadow;
      o_period_strobe <= 1'b0;
    end else begin
      o_period_strobe <= wrap;
      if (tick) begin
        pre_cnt <= '0;
        if (wrap) begin
          counter       <= '0;
          period_active <= period_shadow;
        end else begin
          counter <= counter + WIDTH'(1);
        end
      end else begin
        pre_cnt <= pre_cnt + WIDTH'(1);
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic target_we;
    logic step_we;
    assign target_we = wr_en && (offset == AW'(ch_target_offset(c)));
    assign step_we   = wr_en && (offset == AW'(ch_step_offset(c)));

    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .counter   (counter),
      .wrap      (wrap),
      .run       (run),
      .load      (load),
      .target_we (target_we),
      .step_we   (step_we),
      .wdata     (wdata),
      .target    (ch_target[c]),
      .step      (ch_step[c]),
      .pwm       (o_pwm[c])
    );
  end

  always_comb begin
    rd_val = '0;
    if (offset == AW'(REG_CTRL)) begin
      rd_val[CTRL_RUN_BIT] = run;
    end else if (offset == AW'(REG_PRESCALE)) begin
      rd_val[WIDTH-1:0] = prescale;
    end else if (offset == AW'(REG_PERIOD)) begin
      rd_val[WIDTH-1:0] = period_shadow;
    end else if (offset == AW'(REG_STATUS)) begin
      rd_val[STATUS_PENDING_BIT] = (period_shadow != period_active);
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (offset == AW'(ch_target_offset(c))) rd_val[WIDTH-1:0] = ch_target[c];
      if (offset == AW'(ch_step_offset(c)))   rd_val[WIDTH-1:0] = ch_step[c];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_read_data <= '0;
    end else if (i_read_strobe && in_range) begin
      o_read_data <= rd_val;
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: register access, PWM duty/period,
// fading, mid-period updates, force update and asynchronous reset.
module tb_pwm_bank;

  localparam int CH    = 4;
  localparam int NREGS = 4 + 2 * CH;
  localparam logic [15:0] BASE = 16'h0010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   address;
  logic          wstb;
  logic          rstb;
  logic [15:0]   wdata;
  logic [15:0]   rdata;
  logic [CH-1:0] pwm;
  logic          pstb;

  int checks = 0;
  int errors = 0;
  int m_duty;
  int win_hi [CH];
  int win_stb;
  logic win_end_stb;

  pwm_bank #(
    .CHANNELS(CH), .WIDTH(16), .ADDRESS_BUS_WIDTH(16),
    .DATA_BUS_WIDTH(16), .BASE_ADDRESS(BASE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_address(address),
    .i_write_strobe(wstb), .i_read_strobe(rstb), .i_write_data(wdata),
    .o_read_data(rdata), .o_pwm(pwm), .o_period_strobe(pstb)
  );

  always #5 clk = ~clk;

  function automatic int fade_model(input int d, input int t, input int s);
    if (s == 0) return t;
    if (d < t) return (d + s > t) ? t : d + s;
    if (d > t) return (d - s < t) ? t : d - s;
    return d;
  endfunction

  task automatic reg_write(input int addr, input int data);
    address = 16'(addr);
    wdata   = 16'(data);
    wstb    = 1'b1;
    @(negedge clk);
    wstb    = 1'b0;
  endtask

  task automatic reg_read(input int addr, output logic [15:0] v);
    address = 16'(addr);
    rstb    = 1'b1;
    @(negedge clk);
    rstb    = 1'b0;
    v       = rdata;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (pstb !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (pstb !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s strobe_timeout got none want pulse within 2000 clocks", tag);
    end
  endtask

  task automatic measure(input int len);
    for (int c = 0; c < CH; c++) win_hi[c] = 0;
    win_stb = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) if (pwm[c] === 1'b1) win_hi[c]++;
      if (pstb === 1'b1) win_stb++;
    end
    win_end_stb = pstb;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    logic [15:0] exp;
    checks++;
    if (pwm !== '0) begin errors++; $display("FAIL reset_pwm got %0h want 0", pwm); end
    checks++;
    if (pstb !== 1'b0) begin errors++; $display("FAIL reset_strobe got %0b want 0", pstb); end
    checks++;
    if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %0h want 0", rdata); end
    for (int off = 0; off < NREGS; off++) begin
      reg_read(BASE + off, v);
      exp = (off == 2) ? 16'hFFFF : 16'h0000;
      checks++;
      if (v !== exp) begin errors++; $display("FAIL reset_reg off=%0d got %0h want %0h", off, v, exp); end
    end
    measure(20);
    checks++;
    if (win_stb != 0 || win_hi[0] != 0 || win_hi[CH-1] != 0) begin
      errors++;
      $display("FAIL reset_idle got strobes=%0d hi0=%0d want 0 0", win_stb, win_hi[0]);
    end
  endtask

  task automatic test_readback();
    logic [15:0] v;
    logic [15:0] x;
    int off;
    reg_write(16'h0014, 16'h1234);
    reg_read(16'h0014, v);
    checks++;
    if (v !== 16'h1234) begin errors++; $display("FAIL rb_target0 got %0h want 1234", v); end
    reg_read(16'h00FF, v);
    checks++;
    if (v !== 16'h1234) begin errors++; $display("FAIL rb_out_of_range_ff got %0h want 1234", v); end
    reg_read(BASE - 1, v);
    checks++;
    if (v !== 16'h1234) begin errors++; $display("FAIL rb_below_base got %0h want 1234", v); end
    reg_write(16'h00FF, 16'h5555);
    reg_write(BASE + NREGS, 16'h6666);
    reg_read(BASE + NREGS, v);
    checks++;
    if (v !== 16'h1234) begin errors++; $display("FAIL rb_past_end got %0h want 1234", v); end
    reg_read(16'h0014, v);
    checks++;
    if (v !== 16'h1234) begin errors++; $display("FAIL rb_oor_write got %0h want 1234", v); end
    for (int it = 0; it < 10; it++) begin
      off = $urandom_range(1, NREGS - 1);
      if (off == 3) off = 2;
      x = 16'($urandom);
      reg_write(BASE + off, x);
      reg_read(BASE + off, v);
      checks++;
      if (v !== x) begin errors++; $display("FAIL rb_random off=%0d got %0h want %0h", off, v, x); end
    end
    reg_write(BASE, 16'hFFFF);
    reg_read(BASE, v);
    checks++;
    if (v !== 16'h0001) begin errors++; $display("FAIL rb_ctrl got %0h want 0001", v); end
    reg_write(BASE, 0);
  endtask

  task automatic test_pwm_random();
    int p;
    int n;
    int len;
    int exp;
    int d [CH];
    for (int it = 0; it < 7; it++) begin
      if (it == 0) begin p = 3; n = 1; end
      else begin p = $urandom_range(0, 3); n = $urandom_range(1, 12); end
      for (int c = 0; c < CH; c++) d[c] = $urandom_range(0, n + 3);
      if (it == 0) d[1] = 1;
      if (it == 1) begin d[0] = 0; d[1] = n + 1; d[2] = n; d[3] = 16'hFFFF; end
      if (it == 2) begin p = 0; n = 9; d[0] = 3; end
      reg_write(BASE, 0);
      reg_write(BASE + 1, p);
      reg_write(BASE + 2, n);
      for (int c = 0; c < CH; c++) begin
        reg_write(BASE + 4 + 2 * c, d[c]);
        reg_write(BASE + 5 + 2 * c, 0);
      end
      reg_write(BASE, 1);
      len = (p + 1) * (n + 1);
      repeat (2 * len + 2) @(negedge clk);
      wait_strobe("pwm");
      measure(len);
      checks++;
      if (win_stb != 1 || win_end_stb !== 1'b1) begin
        errors++;
        $display("FAIL pwm_strobe_interval p=%0d n=%0d got strobes=%0d end=%0b want 1 1", p, n, win_stb, win_end_stb);
      end
      for (int c = 0; c < CH; c++) begin
        exp = ((d[c] < n + 1) ? d[c] : n + 1) * (p + 1);
        checks++;
        if (win_hi[c] != exp) begin
          errors++;
          $display("FAIL pwm_duty ch=%0d p=%0d n=%0d d=%0d got %0d want %0d", c, p, n, d[c], win_hi[c], exp);
        end
      end
    end
  endtask

  task automatic fade_run(input int t, input int s, input int nper);
    int exp;
    reg_write(BASE + 5, s);
    reg_write(BASE + 4, t);
    wait_strobe("fade");
    for (int k = 0; k < nper; k++) begin
      m_duty = fade_model(m_duty, t, s);
      measure(10);
      exp = (m_duty > 10) ? 10 : m_duty;
      checks++;
      if (win_hi[0] != exp) begin
        errors++;
        $display("FAIL fade t=%0d s=%0d period=%0d got %0d want %0d", t, s, k, win_hi[0], exp);
      end
    end
    m_duty = fade_model(m_duty, t, s);
  endtask

  task automatic test_fade();
    reg_write(BASE, 0);
    reg_write(BASE + 1, 0);
    reg_write(BASE + 2, 9);
    reg_write(BASE + 4, 0);
    reg_write(BASE + 5, 0);
    reg_write(BASE, 1);
    m_duty = 0;
    wait_strobe("fade_start");
    fade_run(8, 3, 4);
    fade_run(0, 3, 3);
    for (int k = 0; k < 4; k++) fade_run($urandom_range(0, 12), $urandom_range(0, 4), 3);
    fade_run(0, 0, 1);
    fade_run(10, 0, 1);
  endtask

  task automatic test_midperiod_write();
    int hi;
    reg_write(BASE + 4, 3);
    wait_strobe("mid");
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pwm[0] === 1'b1) hi++;
      if (i == 3) begin address = BASE + 4; wdata = 16'd5; wstb = 1'b1; end
      else wstb = 1'b0;
    end
    checks++;
    if (hi != 3) begin errors++; $display("FAIL mid_current_period got %0d want 3", hi); end
    measure(10);
    checks++;
    if (win_hi[0] != 5) begin errors++; $display("FAIL mid_next_period got %0d want 5", win_hi[0]); end
  endtask

  task automatic test_period_change();
    logic [15:0] st;
    int cnt;
    repeat (6) @(negedge clk);
    reg_write(BASE + 2, 3);
    reg_read(BASE + 3, st);
    checks++;
    if (st !== 16'h0001) begin errors++; $display("FAIL status_pending got %0h want 0001", st); end
    cnt = 8;
    while (pstb !== 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
    checks++;
    if (cnt != 10) begin errors++; $display("FAIL period_old_kept got %0d want 10", cnt); end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (pstb !== 1'b1 && cnt < 100);
    checks++;
    if (cnt != 4) begin errors++; $display("FAIL period_new got %0d want 4", cnt); end
    reg_read(BASE + 3, st);
    checks++;
    if (st !== 16'h0000) begin errors++; $display("FAIL status_clear got %0h want 0000", st); end
    repeat (1) @(negedge clk);
    reg_write(BASE, 3);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (pstb !== 1'b1 && cnt < 100);
    checks++;
    if (cnt != 4) begin errors++; $display("FAIL force_update_restart got %0d want 4", cnt); end
  endtask

  task automatic test_async_reset();
    logic [15:0] v;
    int n;
    reg_write(BASE, 0);
    reg_write(BASE + 1, 0);
    reg_write(BASE + 2, 9);
    reg_write(BASE + 4, 0);
    reg_write(BASE + 5, 1);
    reg_write(BASE, 1);
    reg_write(BASE + 4, 200);
    reg_read(BASE + 5, v);
    n = 0;
    while (pwm[0] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (pwm[0] !== 1'b1) begin errors++; $display("FAIL arst_setup got pwm0=%0b want 1", pwm[0]); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (pwm !== '0) begin errors++; $display("FAIL arst_pwm_immediate got %0h want 0", pwm); end
    checks++;
    if (rdata !== 16'h0) begin errors++; $display("FAIL arst_rdata_immediate got %0h want 0", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
  endtask

  initial begin
    rst_n   = 1'b0;
    address = '0;
    wstb    = 1'b0;
    rstb    = 1'b0;
    wdata   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_readback();
    test_pwm_random();
    test_fade();
    test_midperiod_write();
    test_period_change();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
